// File: rtl/pwr_btn_pkg.sv
// Shared types and default 32.768 kHz timing constants for the power-button press generator.
package pwr_btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } pwr_state_e;

  typedef enum logic {
    PT_SHORT = 1'b0,
    PT_LONG  = 1'b1
  } press_type_e;

  // ~200 ms, ~5 s and ~100 ms at 32.768 kHz
  localparam int DEF_CNT_W     = 18;
  localparam int DEF_SHORT_CYC = 6554;
  localparam int DEF_LONG_CYC  = 163840;
  localparam int DEF_GAP_CYC   = 3277;

endpackage

// File: rtl/pwr_btn_tmr.sv
// Loadable down-counter shared by the press and release-gap phases.
// Load has priority; decrement only while enabled and nonzero, so the count never wraps.
module pwr_btn_tmr #(
  parameter int CNT_W = 18
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pwr_btn_drv.sv
// Timed power-button press generator: drives o_pwrbtn_n low for SHORT/LONG cycles, then holds a release gap.
// Optional PWRBTN_REQ_QUEUE_EN adds a one-deep pending slot for requests that arrive while busy.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | button released, ready to accept a request
// ST_PRESS | button driven low, timer counts the press duration
// ST_GAP   | button released, timer enforces the minimum gap
module pwr_btn_drv
  import pwr_btn_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int SHORT_CYC = DEF_SHORT_CYC,
  parameter int LONG_CYC  = DEF_LONG_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC
) (
  input  logic i_clk_32k,
  input  logic i_rst_n,
  input  logic i_req_short,
  input  logic i_req_long,
  input  logic i_abort,
  output logic o_pwrbtn_n,
  output logic o_busy,
  output logic o_done,
  output logic o_aborted
);

  localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(SHORT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

  pwr_state_e       r_state;
  pwr_state_e       w_state_nxt;
  logic             r_pwrbtn_n;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;

  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_ld_val;
  logic             w_tmr_en;
  logic             w_tmr_zero;

  logic             w_launch;
  press_type_e      w_launch_type;
  logic             w_accept;
  logic             w_abort_hit;
  logic             w_finish;

  logic             w_pwrbtn_n_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_aborted_nxt;

`ifdef PWRBTN_REQ_QUEUE_EN
  logic        r_pend_vld;
  press_type_e r_pend_type;

  // A pending long is never demoted by a later short; IDLE always consumes the slot.
  always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_vld  <= 1'b0;
      r_pend_type <= PT_SHORT;
    end else if ((r_state == ST_IDLE) || ((r_state == ST_PRESS) && i_abort)) begin
      r_pend_vld  <= 1'b0;
    end else if (i_req_long) begin
      r_pend_vld  <= 1'b1;
      r_pend_type <= PT_LONG;
    end else if (i_req_short && !(r_pend_vld && (r_pend_type == PT_LONG))) begin
      r_pend_vld  <= 1'b1;
      r_pend_type <= PT_SHORT;
    end
  end

  assign w_launch      = i_req_short | i_req_long | r_pend_vld;
  assign w_launch_type = (i_req_long || (r_pend_vld && (r_pend_type == PT_LONG))) ? PT_LONG
                                                                                   : PT_SHORT;
`else
  assign w_launch      = i_req_short | i_req_long;
  assign w_launch_type = i_req_long ? PT_LONG : PT_SHORT;
`endif

  pwr_btn_tmr #(
    .CNT_W (CNT_W)
  ) u_tmr (
    .i_clk      (i_clk_32k),
    .i_rst_n    (i_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_ld_val),
    .i_en       (w_tmr_en),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Abort is checked before expiry so it wins on the final press cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_tmr_load   = 1'b0;
    w_tmr_ld_val = '0;
    w_tmr_en     = 1'b0;
    w_accept     = 1'b0;
    w_abort_hit  = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) begin
          w_state_nxt  = ST_PRESS;
          w_tmr_load   = 1'b1;
          w_tmr_ld_val = (w_launch_type == PT_LONG) ? LONG_LD : SHORT_LD;
          w_accept     = 1'b1;
        end
      end
      ST_PRESS: begin
        if (i_abort) begin
          w_state_nxt  = ST_GAP;
          w_tmr_load   = 1'b1;
          w_tmr_ld_val = GAP_LD;
          w_abort_hit  = 1'b1;
        end else if (w_tmr_zero) begin
          w_state_nxt  = ST_GAP;
          w_tmr_load   = 1'b1;
          w_tmr_ld_val = GAP_LD;
        end else begin
          w_tmr_en     = 1'b1;
        end
      end
      ST_GAP: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_IDLE;
          w_finish    = 1'b1;
        end else begin
          w_tmr_en    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    w_pwrbtn_n_nxt = (w_state_nxt != ST_PRESS);
    w_busy_nxt     = (w_state_nxt != ST_IDLE);
    w_done_nxt     = w_finish;
    w_aborted_nxt  = r_aborted;
    if (w_accept) begin
      w_aborted_nxt = 1'b0;
    end
    if (w_abort_hit) begin
      w_aborted_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pwrbtn_n <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      r_pwrbtn_n <= w_pwrbtn_n_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_aborted  <= w_aborted_nxt;
    end
  end

  assign o_pwrbtn_n = r_pwrbtn_n;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_aborted  = r_aborted;

endmodule

// File: tb/tb_pwr_btn_drv.sv
// Bench for pwr_btn_drv with short timings; the model tracks each press as a start edge plus low length.
module tb_pwr_btn_drv;

  localparam int SHORT = 8;
  localparam int LONG  = 32;
  localparam int GAP   = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic req_s, req_l, abort;
  logic o_pwrbtn_n, o_busy, o_done, o_aborted;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwr_btn_drv #(
    .CNT_W     (18),
    .SHORT_CYC (SHORT),
    .LONG_CYC  (LONG),
    .GAP_CYC   (GAP)
  ) dut (
    .i_clk_32k   (clk),
    .i_rst_n     (rst_n),
    .i_req_short (req_s),
    .i_req_long  (req_l),
    .i_abort     (abort),
    .o_pwrbtn_n  (o_pwrbtn_n),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_aborted   (o_aborted)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a press started at edge m_s is low for m_l cycles, high+busy for GAP, then done.
  int m_e, m_s, m_l;
  bit m_ab, m_busy, m_pwr, m_done;
  bit pv, pl;

  always @(posedge clk or negedge rst_n) begin
    int pj, j;
    bit was_busy, go, lng;
    if (!rst_n) begin
      m_e = 0; m_s = -100000; m_l = 0;
      m_ab = 0; m_busy = 0; m_pwr = 1; m_done = 0;
      pv = 0; pl = 0;
    end else begin
      was_busy = m_busy;
      pj = m_e - m_s;
      m_e++;
      if (!was_busy) begin
        go  = req_s | req_l;
        lng = req_l;
`ifdef PWRBTN_REQ_QUEUE_EN
        go  = go | pv;
        lng = lng | (pv & pl);
        pv  = 0;
`endif
        if (go) begin
          m_s = m_e;
          m_l = lng ? LONG : SHORT;
          m_ab = 0;
        end
      end else begin
        if (pj < m_l && abort) begin
          m_l = pj + 1;
          m_ab = 1;
          pv = 0;
        end
`ifdef PWRBTN_REQ_QUEUE_EN
        else if (req_l) begin
          pv = 1; pl = 1;
        end else if (req_s && !(pv && pl)) begin
          pv = 1; pl = 0;
        end
`endif
      end
      j = m_e - m_s;
      m_pwr  = !(j >= 0 && j < m_l);
      m_busy = (j >= 0 && j < m_l + GAP);
      m_done = (j == m_l + GAP);
    end
  end

  // Per-cycle comparison plus run-length monitors used by the literal checks.
  int low_run = 0, last_low = 0, gap_run = 0, last_gap = 0;
  int n_press = 0, n_done = 0;
  logic prev_pwr = 1'b1;

  always @(negedge clk) begin
    chk("pwrbtn_n", 32'(o_pwrbtn_n), 32'(m_pwr));
    chk("busy",     32'(o_busy),     32'(m_busy));
    chk("done",     32'(o_done),     32'(m_done));
    chk("aborted",  32'(o_aborted),  32'(m_ab));
    if (o_pwrbtn_n === 1'b0) low_run++;
    else if (low_run != 0) begin last_low = low_run; low_run = 0; end
    if (o_busy === 1'b1 && o_pwrbtn_n === 1'b1) gap_run++;
    else if (gap_run != 0) begin last_gap = gap_run; gap_run = 0; end
    if (prev_pwr === 1'b1 && o_pwrbtn_n === 1'b0) n_press++;
    if (o_done === 1'b1) n_done++;
    prev_pwr = o_pwrbtn_n;
  end

  task automatic pulse(input logic s, input logic l);
    @(negedge clk);
    req_s = s; req_l = l;
    @(negedge clk);
    req_s = 1'b0; req_l = 1'b0;
  endtask

  task automatic settle();
    int quiet = 0;
    int k = 0;
    while (quiet < 3 && k < 400) begin
      @(negedge clk);
      k++;
      quiet = (o_busy === 1'b0) ? quiet + 1 : 0;
    end
    if (quiet < 3) begin
      n_cmp++;
      n_err++;
      $display("FAIL settle_timeout: busy still high after %0d cycles, expected idle", k);
    end
  endtask

  int p0, d0;

  initial begin
    rst_n = 1'b0; req_s = 1'b0; req_l = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pwrbtn_n", 32'(o_pwrbtn_n), 1);
    chk("rst_busy",     32'(o_busy),     0);
    chk("rst_done",     32'(o_done),     0);
    chk("rst_aborted",  32'(o_aborted),  0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // short press
    p0 = n_press; d0 = n_done;
    pulse(1'b1, 1'b0);
    settle();
    chk("short_low",   last_low, SHORT);
    chk("short_gap",   last_gap, GAP);
    chk("short_done",  n_done - d0, 1);
    chk("short_count", n_press - p0, 1);
    chk("short_abt",   32'(o_aborted), 0);

    // both requests: long wins
    pulse(1'b1, 1'b1);
    settle();
    chk("both_low", last_low, LONG);

    // abort at press cycle index 10
    d0 = n_done;
    pulse(1'b0, 1'b1);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    settle();
    chk("abort_low",  last_low, 11);
    chk("abort_gap",  last_gap, GAP);
    chk("abort_done", n_done - d0, 1);
    chk("abort_flag", 32'(o_aborted), 1);
    pulse(1'b1, 1'b0);
    chk("abort_clr",  32'(o_aborted), 0);
    settle();
    chk("after_abort_low", last_low, SHORT);

    // request while busy
    p0 = n_press;
    pulse(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    pulse(1'b1, 1'b0);
    settle();
`ifdef PWRBTN_REQ_QUEUE_EN
    chk("busy_req_count", n_press - p0, 2);
`else
    chk("busy_req_count", n_press - p0, 1);
`endif
    chk("busy_req_low", last_low, SHORT);

    // held request re-triggers in the done cycle
    p0 = n_press;
    @(negedge clk);
    req_s = 1'b1;
    repeat (14) @(negedge clk);
    req_s = 1'b0;
    settle();
    chk("held_count", n_press - p0, 2);

    // reset during press cycle 5
    pulse(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pwrbtn_n", 32'(o_pwrbtn_n), 1);
    chk("midrst_busy",     32'(o_busy),     0);
    chk("midrst_done",     32'(o_done),     0);
    chk("midrst_aborted",  32'(o_aborted),  0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    pulse(1'b1, 1'b0);
    settle();
    chk("post_rst_low", last_low, SHORT);

    // abort coincident with expiry
    pulse(1'b1, 1'b0);
    repeat (7) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    settle();
    chk("lastcyc_low",  last_low, SHORT);
    chk("lastcyc_gap",  last_gap, GAP);
    chk("lastcyc_flag", 32'(o_aborted), 1);

    // abort in IDLE is ignored
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", 32'(o_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwr_btn_drv.md
Name: pwr_btn_drv

Overview:
- Generates a timed power-button press toward the platform (PCH/BMC pin).
- Accepts a short-press or long-press request from CPLD control logic and drives an active-low open-drain-style button output for an exact number of 32 kHz cycles.
- After each press it enforces a minimum release gap before the next request is accepted.
- It is the output counterpart of the button debounce filter: that filter qualifies presses coming in; this block synthesises presses going out.

Parameters:
- CNT_W, 18, width of the duration down-counter.
- SHORT_CYC, 6554, short-press low time in clk cycles (~200 ms at 32.768 kHz); must be ≥1 and < 2^CNT_W.
- LONG_CYC, 163840, long-press (force-off) low time in cycles (~5 s); must be ≥1 and < 2^CNT_W.
- GAP_CYC, 3277, release gap in cycles (~100 ms); must be ≥1.

Ports:
- i_clk_32k  in  1  32.768 kHz clock.
- i_rst_n  in  1  Asynchronous active-low reset.
- i_req_short  in  1  Short-press request, one-cycle pulse or level, same clock domain.
- i_req_long  in  1  Long-press request, same clock domain.
- i_abort  in  1  Terminates an in-progress press early.
- o_pwrbtn_n  out  1  Button drive, 0 = pressed.
- o_busy  out  1  1 while not IDLE.
- o_done  out  1  One-cycle pulse on return to IDLE.
- o_aborted  out  1  Sticky flag: last press was aborted. Cleared on next accepted request.

Behaviour:
- One clock (i_clk_32k); reset is asynchronous and active-low (i_rst_n).
- All outputs are registered.
- Reset values: o_pwrbtn_n=1, o_busy=0, o_done=0, o_aborted=0; state=IDLE; counter=0.
- States:
  - IDLE: o_pwrbtn_n=1, o_busy=0.
  - PRESS: o_pwrbtn_n=0.
  - GAP: o_pwrbtn_n=1, o_busy=1.
- IDLE, on a request sampled high at edge N:
  - Go to PRESS.
  - Counter loads dur-1, where dur=LONG_CYC if i_req_long else SHORT_CYC. Long wins when both are high.
  - o_pwrbtn_n=0 and o_busy=1 from edge N onward.
  - o_aborted cleared.
- PRESS:
  - Counter decrements each cycle.
  - On the cycle the counter is 0, go to GAP with counter=GAP_CYC-1.
  - o_pwrbtn_n is low for exactly dur cycles.
- PRESS with i_abort=1:
  - Go to GAP next edge (o_pwrbtn_n=1), counter=GAP_CYC-1, o_aborted set.
  - Abort has priority over counter expiry in the same cycle.
  - i_abort in IDLE or GAP is ignored.
- GAP:
  - Counter decrements.
  - At 0, go to IDLE with o_done=1 for exactly one cycle; o_busy falls on the same edge.
- Requests arriving while o_busy=1 are dropped, with no queuing (see optional feature).
- A request held high continuously re-triggers a new press in the first IDLE cycle. Callers must pulse.
- A reset assertion mid-press releases o_pwrbtn_n to 1 immediately (async) and discards all state.
- Counter arithmetic is unsigned, CNT_W bits, never wraps: it is only decremented when nonzero.

Optional Feature:
- Macro: PWRBTN_REQ_QUEUE_EN.
- Defined:
  - One-deep pending slot (valid + type bit) captures a request arriving while busy. Long overwrites pending short; short does not overwrite pending long.
  - On GAP→IDLE the pending request launches PRESS on the following edge. o_done still pulses.
  - i_abort also clears the pending slot.
- Undefined: requests while busy are dropped; no extra flops.

Decomposition:
- Shared package pwr_btn_pkg contains:
  - State encoding: IDLE=2'd0, PRESS=2'd1, GAP=2'd2.
  - Default duration constants (32 kHz values).
  - Press-type encoding: SHORT=0, LONG=1.
- Sub-module pwr_btn_tmr: loadable CNT_W down-counter with load, load value, enable, and zero flag. Used for both the PRESS and GAP phases.

Test Plan (SHORT_CYC=8, LONG_CYC=32, GAP_CYC=4):
- Short press: i_req_short pulsed 1 cycle → o_pwrbtn_n low exactly 8 cycles, then high 4 cycles with o_busy=1, then o_done 1-cycle pulse, o_aborted=0.
- Simultaneous requests: i_req_short and i_req_long pulsed together → low exactly 32 cycles.
- Abort: long press with i_abort at press cycle 10 → o_pwrbtn_n high at cycle 11, 4-cycle gap, o_done, o_aborted=1. Next short request clears o_aborted.
- Request while busy:
  - Macro undefined: short pulsed during PRESS → ignored, single press only.
  - Macro defined: a second 8-cycle press begins 1 cycle after o_done.
- Reset mid-press: i_rst_n low during PRESS cycle 5 → o_pwrbtn_n=1 asynchronously, all outputs at reset values. After release, a new request works normally.
- Abort coincident with expiry: i_abort on the final PRESS cycle → GAP entered, o_aborted=1, total low time 8 cycles.
